// File: rtl/descrambler_block_lock.sv
// 64b/66b-style receive block: x^58+x^39+1 self-synchronous descrambler plus
// sync-header block-lock FSM with bitslip request and header error accounting.
module descrambler_block_lock #(
  parameter int DATA_WIDTH = 64,
  parameter int LOCK_CNT   = 64,
  parameter int ERR_MAX    = 16,
  parameter int SLIP_WAIT  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] data_in,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            sync_out,
  output logic                  out_valid,
  output logic                  hdr_err,
  output logic                  block_lock,
  output logic                  slip,
  output logic [7:0]            err_cnt
);

  typedef enum logic [1:0] {RESET_ST, SLIP_ST, LOCKED} lock_state_e;

  localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
  localparam logic [7:0] ERR_TGT  = 8'(ERR_MAX);
  localparam logic [7:0] WAIT_TGT = 8'(SLIP_WAIT);

  lock_state_e           state_q, state_d;
  logic [7:0]            good_q, good_d;
  logic [7:0]            win_q, win_d;
  logic [7:0]            werr_q, werr_d;
  logic [7:0]            wait_q, wait_d;
  logic                  slip_d;
  logic [57:0]           scr_q, scr_d;
  logic [DATA_WIDTH-1:0] dscr;
  logic                  hdr_bad;

  // A header is legal only when its two bits differ (01 or 10).
  assign hdr_bad = (data_in[0] == data_in[1]);

  // Bit-serial descrambler unrolled across the block; payload bit i is data_in[i+2].
  always_comb begin
    scr_d = scr_q;
    dscr  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      dscr[DATA_WIDTH-1-i] = data_in[i+2] ^ scr_d[38] ^ scr_d[57];
      scr_d                = {scr_d[56:0], data_in[i+2]};
    end
  end

  // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    werr_d  = werr_q;
    wait_d  = wait_q;
    slip_d  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        RESET_ST: begin
          if (hdr_bad) begin
            good_d  = '0;
            wait_d  = '0;
            slip_d  = 1'b1;
            state_d = SLIP_ST;
          end else if (good_q + 8'd1 == LOCK_TGT) begin
            good_d  = '0;
            win_d   = '0;
            werr_d  = '0;
            state_d = LOCKED;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        SLIP_ST: begin
          if (wait_q + 8'd1 == WAIT_TGT) begin
            wait_d  = '0;
            good_d  = '0;
            state_d = RESET_ST;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
        LOCKED: begin
          // Loss of lock is tested first so it wins on the last block of a window.
          if (werr_q + {7'd0, hdr_bad} == ERR_TGT) begin
            win_d   = '0;
            werr_d  = '0;
            good_d  = '0;
            state_d = RESET_ST;
          end else if (win_q + 8'd1 == LOCK_TGT) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 8'd1;
            werr_d = werr_q + {7'd0, hdr_bad};
          end
        end
        default: state_d = RESET_ST;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RESET_ST;
      good_q     <= '0;
      win_q      <= '0;
      werr_q     <= '0;
      wait_q     <= '0;
      scr_q      <= '1;
      data_out   <= '0;
      sync_out   <= 2'b00;
      out_valid  <= 1'b0;
      hdr_err    <= 1'b0;
      block_lock <= 1'b0;
      slip       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      win_q      <= win_d;
      werr_q     <= werr_d;
      wait_q     <= wait_d;
      slip       <= slip_d;
      block_lock <= (state_d == LOCKED);
      out_valid  <= in_valid;
      if (in_valid) begin
        scr_q    <= scr_d;
        data_out <= dscr;
        sync_out <= data_in[1:0];
        hdr_err  <= hdr_bad;
        if (hdr_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_descrambler_block_lock.sv
// Directed bench: phase table drives header patterns through three widths
// (32/64/128) while a reference scrambler feeds payloads for bit-exact checks.
module tb_descrambler_block_lock;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [33:0]  din32;
  logic [65:0]  din64;
  logic [129:0] din128;

  logic [31:0]  dout32;
  logic [63:0]  dout64;
  logic [127:0] dout128;
  logic [1:0]   sync32, sync64, sync128;
  logic         ov32, ov64, ov128, he32, he64, he128;
  logic         lk32, lk64, lk128, sl32, sl64, sl128;
  logic [7:0]   ec32, ec64, ec128;

  always #5 clk = ~clk;

  descrambler_block_lock #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .data_in(din32), .in_valid(in_valid),
    .data_out(dout32), .sync_out(sync32), .out_valid(ov32), .hdr_err(he32),
    .block_lock(lk32), .slip(sl32), .err_cnt(ec32));

  descrambler_block_lock #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .data_in(din64), .in_valid(in_valid),
    .data_out(dout64), .sync_out(sync64), .out_valid(ov64), .hdr_err(he64),
    .block_lock(lk64), .slip(sl64), .err_cnt(ec64));

  descrambler_block_lock #(.DATA_WIDTH(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .data_in(din128), .in_valid(in_valid),
    .data_out(dout128), .sync_out(sync128), .out_valid(ov128), .hdr_err(he128),
    .block_lock(lk128), .slip(sl128), .err_cnt(ec128));

  typedef struct {
    int         n;
    logic [1:0] hdr;
    logic       vld;
    logic       zero;
    logic       reseed;
    logic       exp_lock;
    int         exp_slips;
    logic [7:0] exp_err;
  } phase_t;

  int          checks = 0;
  int          errors = 0;
  int          skip   = 0;
  logic        lock_prev = 1'b0;
  logic [57:0] st32, st64, st128;

  task automatic check(input string name, input logic [129:0] got, input logic [129:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic scramble(input int w, input logic [1:0] hdr, input logic [127:0] pl,
                          inout logic [57:0] st, output logic [129:0] blk);
    blk      = '0;
    blk[1:0] = hdr;
    for (int i = 0; i < w; i++) begin
      blk[i+2] = pl[i] ^ st[38] ^ st[57];
      st       = {st[56:0], blk[i+2]};
    end
  endtask

  function automatic logic [127:0] expect_out(input int w, input logic [127:0] pl);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = pl[i];
    return r;
  endfunction

  task automatic step(input logic [1:0] hdr, input logic vld, input logic zero, input logic chk);
    logic [127:0] pl;
    logic [129:0] blk;
    logic         bad;
    pl  = zero ? '0 : {$urandom, $urandom, $urandom, $urandom};
    bad = (hdr == 2'b00) || (hdr == 2'b11);
    @(negedge clk);
    in_valid = vld;
    if (vld) begin
      scramble(32, hdr, pl, st32, blk);   din32  = blk[33:0];
      scramble(64, hdr, pl, st64, blk);   din64  = blk[65:0];
      scramble(128, hdr, pl, st128, blk); din128 = blk;
    end else begin
      din32  = {$urandom, $urandom};
      din64  = {$urandom, $urandom, $urandom};
      din128 = {$urandom, $urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #1;
    check("out_valid32", ov32, vld);
    check("out_valid64", ov64, vld);
    check("out_valid128", ov128, vld);
    if (vld) begin
      check("sync_out", sync64, hdr);
      check("hdr_err", he64, bad);
      if (chk) begin
        check("data32", dout32, expect_out(32, pl));
        check("data64", dout64, expect_out(64, pl));
        check("data128", dout128, expect_out(128, pl));
      end
    end
  endtask

  task automatic run_phase(input int idx, input phase_t p);
    int          s32 = 0, s64 = 0, s128 = 0;
    logic [63:0] seed;
    if (p.reseed) begin
      seed = {$urandom, $urandom}; st32  = seed[57:0];
      seed = {$urandom, $urandom}; st64  = seed[57:0];
      seed = {$urandom, $urandom}; st128 = seed[57:0];
      skip = 2;
    end
    for (int i = 0; i < p.n; i++) begin
      step(p.hdr, p.vld, p.zero, skip == 0);
      if (p.vld && skip > 0) skip--;
      s32 += int'(sl32); s64 += int'(sl64); s128 += int'(sl128);
      if (i < p.n - 1) check($sformatf("lock_hold_p%0d", idx), lk64, lock_prev);
    end
    check($sformatf("slips32_p%0d", idx), s32, p.exp_slips);
    check($sformatf("slips64_p%0d", idx), s64, p.exp_slips);
    check($sformatf("slips128_p%0d", idx), s128, p.exp_slips);
    check($sformatf("lock32_p%0d", idx), lk32, p.exp_lock);
    check($sformatf("lock64_p%0d", idx), lk64, p.exp_lock);
    check($sformatf("lock128_p%0d", idx), lk128, p.exp_lock);
    check($sformatf("err_cnt32_p%0d", idx), ec32, p.exp_err);
    check($sformatf("err_cnt64_p%0d", idx), ec64, p.exp_err);
    check($sformatf("err_cnt128_p%0d", idx), ec128, p.exp_err);
    lock_prev = p.exp_lock;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_data32"}, dout32, 32'd0);
    check({tag, "_data64"}, dout64, 64'd0);
    check({tag, "_data128"}, dout128, 128'd0);
    check({tag, "_sync"}, {sync32, sync64, sync128}, 6'd0);
    check({tag, "_out_valid"}, {ov32, ov64, ov128}, 3'd0);
    check({tag, "_hdr_err"}, {he32, he64, he128}, 3'd0);
    check({tag, "_lock"}, {lk32, lk64, lk128}, 3'd0);
    check({tag, "_slip"}, {sl32, sl64, sl128}, 3'd0);
    check({tag, "_err_cnt"}, {ec32, ec64, ec128}, 24'd0);
  endtask

  // Reset with an invalid block on the inputs, so any pending slip must be dropped.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    din32    = {$urandom, $urandom};  din32[1:0]  = 2'b11;
    din64    = {$urandom, $urandom, $urandom}; din64[1:0] = 2'b11;
    din128   = {$urandom, $urandom, $urandom, $urandom, $urandom}; din128[1:0] = 2'b11;
    @(posedge clk);
    #1;
    check_reset_outs(tag);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    st32      = '1;
    st64      = '1;
    st128     = '1;
    skip      = 0;
    lock_prev = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    phase_t ph[$];
    //        n    hdr   vld   zero  rsd   lock  slips err
    ph.push_back('{63,  2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'd0});
    ph.push_back('{1,   2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 0, 8'd0});
    ph.push_back('{15,  2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'd15});
    ph.push_back('{49,  2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 0, 8'd15});
    ph.push_back('{15,  2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'd30});
    ph.push_back('{1,   2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd31});
    ph.push_back('{10,  2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd31});
    ph.push_back('{1,   2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'd32});
    ph.push_back('{10,  2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd32});
    ph.push_back('{2,   2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd34});
    ph.push_back('{20,  2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd34});
    ph.push_back('{63,  2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd34});
    ph.push_back('{1,   2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'd34});
    ph.push_back('{10,  2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'd34});
    ph.push_back('{48,  2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'd34});
    ph.push_back('{15,  2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'd49});
    ph.push_back('{1,   2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd50});
    ph.push_back('{210, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 7, 8'd255});

    rst_n    = 1'b0;
    in_valid = 1'b0;
    din32    = '0;
    din64    = '0;
    din128   = '0;
    st32     = '1;
    st64     = '1;
    st128    = '1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (ph[k]) run_phase(k, ph[k]);

    // The last phase leaves the FSM mid-slip-wait.
    reset_pulse("rst_in_slip");
    run_phase(100, '{1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'd1});
    reset_pulse("rst_pending_slip");
    run_phase(101, '{64, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'd0});
    reset_pulse("rst_in_locked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/descrambler_block_lock.md
DESCRAMBLER_BLOCK_LOCK -- requirements
Module: descrambler_block_lock

Interface
- Parameters, one per line: name, default, meaning.
- REQ-001 DATA_WIDTH, 64, payload bits per block; legal range 32..128.
- REQ-002 LOCK_CNT, 64, consecutive valid headers required to declare lock; legal range 2..255.
- REQ-003 ERR_MAX, 16, invalid headers within one LOCK_CNT-block window that force loss of lock; legal range 1..LOCK_CNT.
- REQ-004 SLIP_WAIT, 32, blocks ignored after a slip request; legal range 1..255.
- Ports, one per line: name, direction, width, meaning.
- REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
- REQ-006 rst_n  in  1  synchronous, active-low reset.
- REQ-007 data_in  in  DATA_WIDTH+2  received block; bit 0 is received first; bits [0:1] are the sync header; bits [2:DATA_WIDTH+1] are the scrambled payload.
- REQ-008 in_valid  in  1  data_in qualifier; with in_valid low, no internal state changes.
- REQ-009 data_out  out  DATA_WIDTH  descrambled payload; MSB is the first received payload bit.
- REQ-010 sync_out  out  2  registered sync header of the same block.
- REQ-011 out_valid  out  1  data_out and sync_out are valid.
- REQ-012 hdr_err  out  1  registered flag: the header of the output block was 00 or 11.
- REQ-013 block_lock  out  1  lock state; high only in state LOCKED.
- REQ-014 slip  out  1  single-cycle bitslip request to the deserializer.
- REQ-015 err_cnt  out  8  saturating count of invalid headers since reset.

Function
- REQ-016 Descrambling uses the self-synchronous polynomial x^58 + x^39 + 1 with a 58-bit state; per payload bit in receive order: out = in ^ s[38] ^ s[57]; then s = {s[56:0], in}.
- REQ-017 A valid input block processes all DATA_WIDTH bits in one cycle; the state advances only on cycles with in_valid high.
- REQ-018 Latency is exactly 1 cycle: out_valid, data_out, sync_out and hdr_err are registered one cycle after in_valid; out_valid is low on cycles that follow in_valid low.
- REQ-019 Descrambling runs in every lock state; block_lock is advisory only.
- REQ-020 A header is valid when it is 01 or 10.
- REQ-021 The lock FSM has three states: RESET_ST, SLIP_ST and LOCKED; all counters advance only on valid blocks.
- REQ-022 RESET_ST: good_cnt increments on each valid header. Once good_cnt reaches LOCKED_CNT, the FSM moves to LOCKED and both counters clear. An invalid header clears good_cnt, pulses slip for 1 cycle and moves the FSM to SLIP_ST.
- REQ-023 SLIP_ST: the FSM ignores SLIP_WAIT valid blocks and then returns to RESET_ST with good_cnt = 0; slip never pulses in this state.
- REQ-024 LOCKED: a window counter counts blocks up to LOCK_CNT and an error counter counts invalid headers. When the error counter reaches ERR_MAX, the FSM goes to RESET_ST with no slip and both counters clear. When the window completes first, both counters clear and the FSM stays LOCKED.
- REQ-025 If the final block of a window is also the ERR_MAX-th error, loss of lock takes priority.
- REQ-026 block_lock is registered and changes in the cycle following the header that causes the transition.
- REQ-027 err_cnt increments on every invalid header in every state and saturates at 255 without wrapping.
- REQ-028 Counter widths are sized for their parameter maximums; no counter wraps.

Reset
- REQ-029 While rst_n is low at a rising clk edge, the following take these values: descrambler state all ones; data_out 0; sync_out 00; out_valid, hdr_err, block_lock and slip 0; err_cnt 0; all counters 0; FSM RESET_ST.
- REQ-030 Reset asserted mid-stream or mid-slip takes effect at the next edge; a pending slip or transition is discarded.

Verification
- REQ-031 After reset, send 64 blocks with header 01 and scrambled all-zero payload -> data_out = 0 for every block; block_lock rises 1 cycle after block 64; slip is never asserted.
- REQ-032 While unlocked, send one header 11 -> exactly one slip pulse, hdr_err = 1, err_cnt = 1. The next 32 headers, including invalid ones, produce no slip. Lock then requires 64 further valid headers.
- REQ-033 While locked, send 15 invalid headers in one window -> lock is held. Send 16 invalid headers in one window -> block_lock falls after the 16th and slip stays 0.
- REQ-034 While locked, stall with in_valid low for 10 cycles mid-stream -> out_valid stays low and the descrambled output after the stall matches the golden model bit-exactly.
- REQ-035 Send random payloads through a reference scrambler, starting the scrambler from an arbitrary seed -> after the first block (58 bits), all output payload bits match the source payload.
- REQ-036 Assert rst_n low during SLIP_ST and during LOCKED -> all outputs take their reset values 1 cycle later; run at DATA_WIDTH = 32 and 128 as well as 64.
